// File: rtl/demux_1x4_rr_sched.sv
// demux_1x4_rr_sched: round-robin burst scheduler driving a two-stage 1:4 demux tree
module demux_1x4_rr_sched #(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4,
    parameter int STALL_MAX = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_ready,
    input  logic [3:0]        in_dst_ready,
    input  logic              in_mode,
    input  logic [1:0]        in_fixed_sel,
    output logic              out_s1,
    output logic              out_s2,
    output logic [DATA_W-1:0] out_y_1,
    output logic [DATA_W-1:0] out_y_2,
    output logic [DATA_W-1:0] out_y_3,
    output logic [DATA_W-1:0] out_y_4,
    output logic [3:0]        out_valid
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int SW = STALL_MAX > 1 ? $clog2(STALL_MAX) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt, grant, grant_nxt, pick;
    logic [BW-1:0]     beat_cnt, beat_nxt;
    logic [SW-1:0]     stall_cnt, stall_nxt;
    logic              xfer, found;
    logic [DATA_W-1:0] y [4];

    assign found     = |in_dst_ready;
    assign out_ready = (state == ACTIVE) && in_dst_ready[grant];
    assign xfer      = in_valid && out_ready;
    assign out_s1    = grant[1];
    assign out_s2    = grant[0];
    assign out_y_1   = y[0];
    assign out_y_2   = y[1];
    assign out_y_3   = y[2];
    assign out_y_4   = y[3];

    // first ready destination at or after ptr; scanning from the far end lets the nearest win
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--)
            if (in_dst_ready[ptr + 2'(i)]) pick = ptr + 2'(i);
    end

    // next state: arbitrate in IDLE, count beats and stalls in ACTIVE
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        beat_nxt  = beat_cnt;
        stall_nxt = stall_cnt;
        if (state == IDLE) begin
            if (in_valid && (in_mode || found)) begin
                state_nxt = ACTIVE;
                grant_nxt = in_mode ? in_fixed_sel : pick;
                beat_nxt  = '0;
                stall_nxt = '0;
            end
        end else if (xfer) begin
            stall_nxt = '0;
            if (beat_cnt == BW'(BURST_LEN - 1)) begin
                state_nxt = IDLE;
                ptr_nxt   = grant + 2'd1;
                beat_nxt  = '0;
            end else begin
                beat_nxt = beat_cnt + 1'b1;
            end
        end else if (in_valid) begin
            if (stall_cnt == SW'(STALL_MAX - 1)) begin
                state_nxt = IDLE;
                ptr_nxt   = grant + 2'd1;
                stall_nxt = '0;
            end else begin
                stall_nxt = stall_cnt + 1'b1;
            end
        end
    end

    // state registers plus the routed data and one-cycle strobe
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            out_valid <= '0;
            y         <= '{default: '0};
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            beat_cnt  <= beat_nxt;
            stall_cnt <= stall_nxt;
            out_valid <= xfer ? 4'b0001 << grant : 4'b0000;
            if (xfer) y[grant] <= in_data;
        end
    end
endmodule

// File: tb/tb_demux_1x4_rr_sched.sv
// tb_demux_1x4_rr_sched: directed stimulus with a scoreboard checked by an independent monitor
module tb_demux_1x4_rr_sched;
    logic       in_clk = 1'b0;
    logic       in_rst, in_valid, out_ready, in_mode, out_s1, out_s2;
    logic [0:0] in_data, out_y_1, out_y_2, out_y_3, out_y_4;
    logic [3:0] in_dst_ready, out_valid;
    logic [1:0] in_fixed_sel;

    typedef struct {
        int   idx;
        logic data;
        int   cyc;
    } exp_t;

    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          seq = 0;
    logic [15:0] pat = 16'b0110_1001_1101_1101;

    demux_1x4_rr_sched #(.DATA_W(1), .BURST_LEN(4), .STALL_MAX(8)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .in_dst_ready(in_dst_ready), .in_mode(in_mode),
        .in_fixed_sel(in_fixed_sel), .out_s1(out_s1), .out_s2(out_s2),
        .out_y_1(out_y_1), .out_y_2(out_y_2), .out_y_3(out_y_3), .out_y_4(out_y_4),
        .out_valid(out_valid)
    );

    always #5 in_clk = ~in_clk;

    // cycle count used to check the one-cycle strobe latency
    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: every strobe must match the oldest expected beat
    always @(negedge in_clk) begin
        exp_t e;
        logic got;
        if (out_valid !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(out_valid), 32'd0);
            end else begin
                e   = sb.pop_front();
                got = e.idx == 0 ? out_y_1 : e.idx == 1 ? out_y_2 : e.idx == 2 ? out_y_3 : out_y_4;
                chk("strobe_onehot", 32'(out_valid), 32'(4'b0001 << e.idx));
                chk("strobe_data", 32'(got), 32'(e.data));
                chk("strobe_latency", cyc, e.cyc);
            end
        end
    end

    // one cycle: drive, check at the falling edge, record accepted beats
    task automatic cy(input logic r, input logic v, input logic [3:0] rdy, input logic m,
                      input logic [1:0] fs, input logic er, input int es, input logic z);
        in_rst       = r;
        in_valid     = v;
        in_data      = pat[seq % 16];
        in_dst_ready = rdy;
        in_mode      = m;
        in_fixed_sel = fs;
        seq++;
        @(negedge in_clk);
        chk("out_ready", 32'(out_ready), 32'(er));
        if (es >= 0) chk("select", 32'({out_s1, out_s2}), es);
        if (z) begin
            chk("zero_valid", 32'(out_valid), 32'd0);
            chk("zero_sel", 32'({out_s1, out_s2}), 32'd0);
            chk("zero_y", 32'({out_y_4, out_y_3, out_y_2, out_y_1}), 32'd0);
        end
        if (!r && v && out_ready) sb.push_back('{es < 0 ? 0 : es, in_data, cyc + 1});
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        // reset held two cycles with a pending source
        for (int i = 0; i < 2; i++) cy(1, 1, 4'hF, 0, 0, 0, -1, 1);
        // round-robin rotation y_1..y_4 then y_1, one IDLE cycle between bursts
        for (int c = 0; c < 25; c++)
            cy(0, 1, 4'hF, 0, 0, c % 5 != 0, c % 5 != 0 ? (c / 5) % 4 : -1, 0);
        // ptr=1 with only y_1 and y_4 ready picks y_4, then wraps to y_1
        cy(0, 1, 4'b1001, 0, 0, 0, -1, 0);
        for (int i = 0; i < 4; i++) cy(0, 1, 4'b1001, 0, 0, 1, 3, 0);
        cy(0, 1, 4'b1001, 0, 0, 0, -1, 0);
        for (int i = 0; i < 4; i++) cy(0, 1, 4'b1001, 0, 0, 1, 0, 0);
        // stall abort on y_2 after one beat and eight stalled cycles; next grant is y_3
        cy(0, 1, 4'hF, 0, 0, 0, -1, 0);
        cy(0, 1, 4'hF, 0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) cy(0, 1, 4'b1101, 0, 0, 0, 1, 0);
        cy(0, 1, 4'hF, 0, 0, 0, -1, 0);
        // y_3 burst: idle source cycles do not advance the stall count
        cy(0, 1, 4'hF, 0, 0, 1, 2, 0);
        for (int i = 0; i < 5; i++) cy(0, 1, 4'b1011, 0, 0, 0, 2, 0);
        for (int i = 0; i < 5; i++) cy(0, 0, 4'b1011, 0, 0, 0, 2, 0);
        for (int i = 0; i < 2; i++) cy(0, 1, 4'b1011, 0, 0, 0, 2, 0);
        for (int i = 0; i < 3; i++) cy(0, 1, 4'hF, 0, 0, 1, 2, 0);
        // fixed mode to y_3 with no one ready, then ready after 3 cycles; mode flip mid-burst ignored
        cy(0, 1, 4'b0000, 1, 2, 0, -1, 0);
        for (int i = 0; i < 3; i++) cy(0, 1, 4'b0000, 1, 2, 0, 2, 0);
        for (int i = 0; i < 2; i++) cy(0, 1, 4'b0100, 1, 2, 1, 2, 0);
        for (int i = 0; i < 2; i++) cy(0, 1, 4'b0100, 0, 0, 1, 2, 0);
        // round-robin resumes at y_4; reset after beat 2 discards the burst
        cy(0, 1, 4'hF, 0, 0, 0, -1, 0);
        for (int i = 0; i < 2; i++) cy(0, 1, 4'hF, 0, 0, 1, 3, 0);
        cy(1, 1, 4'hF, 0, 0, 1, 3, 0);
        cy(0, 1, 4'hF, 0, 0, 0, -1, 1);
        for (int i = 0; i < 4; i++) cy(0, 1, 4'hF, 0, 0, 1, 0, 0);
        // drain with the source idle
        for (int i = 0; i < 3; i++) cy(0, 0, 4'hF, 0, 0, 0, -1, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
